maze_env: RTL

//  Closed-loop maze model that drives the robot FSM's sensor inputs from its front/turn commands.

---
 rtl/maze_pkg.sv | 38 +++
 rtl/maze_wall_ram.sv | 50 +++++
 rtl/maze_env.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze environment.
//   - heading encoding (N/E/S/W, clockwise)
//   - bit positions inside a 4-bit cell wall word {W,S,E,N}
//   - heading rotation helpers and border-wall helper
package maze_pkg;

    localparam logic [1:0] HD_N = 2'd0;
    localparam logic [1:0] HD_E = 2'd1;
    localparam logic [1:0] HD_S = 2'd2;
    localparam logic [1:0] HD_W = 2'd3;

    localparam int unsigned WB_N = 0;
    localparam int unsigned WB_E = 1;
    localparam int unsigned WB_S = 2;
    localparam int unsigned WB_W = 3;

    // Headings are numbered clockwise, so a right turn is +1 and a left turn is -1 (mod 4).
    function automatic logic [1:0] rot_r(input logic [1:0] hd);
        return hd + 2'd1;
    endfunction

    function automatic logic [1:0] rot_l(input logic [1:0] hd);
        return hd - 2'd1;
    endfunction

    // Walls implied by the maze outline for cell (x,y) in a w x h maze.
    function automatic logic [3:0] border_walls(input int unsigned x, input int unsigned y,
                                                input int unsigned w, input int unsigned h);
        logic [3:0] b;
        b       = '0;
        b[WB_N] = (y == 0);
        b[WB_E] = (x == w - 1);
        b[WB_S] = (y == h - 1);
        b[WB_W] = (x == 0);
        return b;
    endfunction

endpackage

// File: rtl/maze_wall_ram.sv
// Wall map for the maze: W*H cells of 4 wall bits {W,S,E,N}.
//   clk, rst_n            clock, async active-low reset (clears the map)
//   we_i/waddr_i/wdata_i  synchronous write; addresses >= W*H are dropped
//   ra_x_i/ra_y_i -> ra_data_o   async read port A
//   rb_x_i/rb_y_i -> rb_data_o   async read port B
// Both read ports OR in the outline walls, so border cells always report a wall outward.
module maze_wall_ram
    import maze_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned H = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [3:0] wdata_i,
    input  logic [3:0] ra_x_i,
    input  logic [3:0] ra_y_i,
    output logic [3:0] ra_data_o,
    input  logic [3:0] rb_x_i,
    input  logic [3:0] rb_y_i,
    output logic [3:0] rb_data_o
);

    localparam int unsigned Cells = W * H;
    localparam int unsigned AW    = (Cells > 1) ? $clog2(Cells) : 1;

    logic [3:0]    mem_q [Cells];
    logic [AW-1:0] ra_idx;
    logic [AW-1:0] rb_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Cells); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (32'(waddr_i) < Cells)) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // Read coordinates always come from a legal pose, so the index stays below Cells.
    assign ra_idx = AW'(32'(ra_y_i) * W + 32'(ra_x_i));
    assign rb_idx = AW'(32'(rb_y_i) * W + 32'(rb_x_i));

    assign ra_data_o = mem_q[ra_idx] | border_walls(32'(ra_x_i), 32'(ra_y_i), W, H);
    assign rb_data_o = mem_q[rb_idx] | border_walls(32'(rb_x_i), 32'(rb_y_i), W, H);

endmodule

// File: rtl/maze_env.sv
// Closed-loop maze model: executes the controller's front/turn command on each step_en_i
// pulse and returns registered front/left wall sensors for the next decision.
//   clk, rst_n                      clock, async active-low reset
//   wall_we_i/wall_addr_i/wall_data_i  wall map load port (priority over stepping)
//   restart_i                       sync return to start pose, clears status, keeps map
//   step_en_i, front_i, turn_i      command strobe and command bits
//   front_sensor_o, left_sensor_o   walls ahead / to the left of the current pose
//   pos_x_o, pos_y_o, heading_o     current pose
//   bump_o, cmd_err_o               one-cycle pulses for refused move / illegal command
//   done_o                          sticky goal-reached flag
//   steps_o                         accepted steps, saturating
module maze_env
    import maze_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned H        = 8,
    parameter int unsigned START_X  = 0,
    parameter int unsigned START_Y  = 0,
    parameter int unsigned START_HD = 0,
    parameter int unsigned GOAL_X   = 7,
    parameter int unsigned GOAL_Y   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wall_we_i,
    input  logic [7:0]  wall_addr_i,
    input  logic [3:0]  wall_data_i,
    input  logic        restart_i,
    input  logic        step_en_i,
    input  logic        front_i,
    input  logic        turn_i,
    output logic        front_sensor_o,
    output logic        left_sensor_o,
    output logic [3:0]  pos_x_o,
    output logic [3:0]  pos_y_o,
    output logic [1:0]  heading_o,
    output logic        bump_o,
    output logic        cmd_err_o,
    output logic        done_o,
    output logic [15:0] steps_o
);

    localparam logic [3:0] StartX     = 4'(START_X);
    localparam logic [3:0] StartY     = 4'(START_Y);
    localparam logic [1:0] StartHd    = 2'(START_HD);
    localparam logic [3:0] GoalX      = 4'(GOAL_X);
    localparam logic [3:0] GoalY      = 4'(GOAL_Y);
    // The map is empty after reset, so the start sensors see only the outline.
    localparam logic [3:0] StartWalls = border_walls(START_X, START_Y, W, H);
    localparam logic       StartFront = StartWalls[START_HD % 4];
    localparam logic       StartLeft  = StartWalls[(START_HD + 3) % 4];

    logic [3:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  hd_q, hd_d;
    logic        front_q, front_d, left_q, left_d;
    logic        bump_q, bump_d, err_q, err_d, done_q, done_d;
    logic [15:0] steps_q, steps_d;
    logic [3:0]  cur_walls, nxt_walls;
    logic        step_go;

    maze_wall_ram #(
        .W (W),
        .H (H)
    ) u_wall_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (wall_we_i),
        .waddr_i   (wall_addr_i),
        .wdata_i   (wall_data_i),
        .ra_x_i    (x_q),
        .ra_y_i    (y_q),
        .ra_data_o (cur_walls),
        .rb_x_i    (x_d),
        .rb_y_i    (y_d),
        .rb_data_o (nxt_walls)
    );

    assign step_go = step_en_i & ~wall_we_i & ~done_q;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        hd_d    = hd_q;
        bump_d  = 1'b0;
        err_d   = 1'b0;
        done_d  = done_q;
        steps_d = steps_q;
        if (restart_i) begin
            x_d     = StartX;
            y_d     = StartY;
            hd_d    = StartHd;
            done_d  = 1'b0;
            steps_d = '0;
        end else if (step_go) begin
            if (steps_q != 16'hFFFF) begin
                steps_d = steps_q + 16'd1;
            end
            case ({front_i, turn_i})
                2'b01: hd_d = rot_r(hd_q);
                2'b10: begin
                    // The live map decides the move; the sensor register may lag a map write.
                    if (cur_walls[hd_q]) begin
                        bump_d = 1'b1;
                    end else begin
                        unique case (hd_q)
                            HD_N: y_d = y_q - 4'd1;
                            HD_E: x_d = x_q + 4'd1;
                            HD_S: y_d = y_q + 4'd1;
                            HD_W: x_d = x_q - 4'd1;
                        endcase
                    end
                end
                2'b11:   err_d = 1'b1;
                default: ;
            endcase
            if ((x_d == GoalX) && (y_d == GoalY)) begin
                done_d = 1'b1;
            end
        end
    end

    // Sensors describe the pose that becomes current on this edge.
    always_comb begin
        front_d = nxt_walls[hd_d];
        left_d  = nxt_walls[rot_l(hd_d)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= StartX;
            y_q     <= StartY;
            hd_q    <= StartHd;
            front_q <= StartFront;
            left_q  <= StartLeft;
            bump_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            steps_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hd_q    <= hd_d;
            front_q <= front_d;
            left_q  <= left_d;
            bump_q  <= bump_d;
            err_q   <= err_d;
            done_q  <= done_d;
            steps_q <= steps_d;
        end
    end

    assign front_sensor_o = front_q;
    assign left_sensor_o  = left_q;
    assign pos_x_o        = x_q;
    assign pos_y_o        = y_q;
    assign heading_o      = hd_q;
    assign bump_o         = bump_q;
    assign cmd_err_o      = err_q;
    assign done_o         = done_q;
    assign steps_o        = steps_q;

endmodule
